// File: rtl/datapath_seq_if.sv
// Command/bus interface of datapath_seq: command handshake, done strobe and internal bus view.
interface datapath_seq_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_rd;
  logic [AW-1:0]    cmd_rs;
  logic [AW-1:0]    cmd_rt;
  logic [WIDTH-1:0] cmd_imm;
  logic             done;
  logic [WIDTH-1:0] bus_out;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm,
    input  cmd_ready, done, bus_out
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm,
    output cmd_ready, done, bus_out
  );
endinterface

// File: rtl/datapath_seq.sv
// Single-bus datapath (register file, Y latch, ALU, Z) with a built-in read/read/write-back sequencer.
// Optional status flags flag_z/flag_n/flag_c are built only when DATAPATH_FLAGS_EN is defined.
module datapath_seq #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_clear,
  datapath_seq_if.slave    bus_if,
  input  logic [AW-1:0]    i_dbg_sel,
  output logic [WIDTH-1:0] o_dbg_data
`ifdef DATAPATH_FLAGS_EN
  ,
  output logic             o_flag_z,
  output logic             o_flag_n,
  output logic             o_flag_c
`endif
);

  // state   | meaning
  // ST_IDLE | bus idle at 0, ready for a command
  // ST_T1   | bus = R[rs], Y <- bus
  // ST_T2   | bus = R[rt] or imm, Z <- ALU / bus
  // ST_T3   | bus = Z, R[rd] <- bus, done
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  localparam int SW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_rs;
  logic [AW-1:0]    r_rt;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_regs [DEPTH];

  logic [WIDTH-1:0] w_bus;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SW-1:0]    w_shamt;
  logic             w_ready;
  logic             w_done;
  logic             w_ld_y;
  logic             w_ld_z;
  logic             w_wb;
  logic             w_accept;

  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bus       = '0;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_ld_y      = 1'b0;
    w_ld_z      = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus_if.cmd_valid) begin
          w_state_nxt = (bus_if.cmd_op == OP_LDI) ? ST_T2 : ST_T1;
        end
      end
      ST_T1: begin
        w_bus       = r_regs[r_rs];
        w_ld_y      = 1'b1;
        w_state_nxt = ST_T2;
      end
      ST_T2: begin
        w_bus       = (r_op == OP_LDI) ? r_imm : r_regs[r_rt];
        w_ld_z      = 1'b1;
        w_state_nxt = ST_T3;
      end
      default: begin
        w_bus       = r_z;
        w_done      = 1'b1;
        w_wb        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = w_ready & bus_if.cmd_valid;

  // Upper bits of the bus are ignored for shifts, so the amount is always below WIDTH.
  assign w_shamt = w_bus[SW-1:0];

`ifdef DATAPATH_FLAGS_EN
  logic [WIDTH:0] w_sum_ext;
  logic [WIDTH:0] w_diff_ext;
  logic           w_carry;
  logic           r_flag_z;
  logic           r_flag_n;
  logic           r_flag_c;

  assign w_sum_ext  = {1'b0, r_y} + {1'b0, w_bus};
  assign w_diff_ext = {1'b0, r_y} - {1'b0, w_bus};
  assign w_sum      = w_sum_ext[WIDTH-1:0];
  assign w_diff     = w_diff_ext[WIDTH-1:0];

  // SUB reports NOT borrow, i.e. 1 when Y >= B unsigned.
  always_comb begin
    w_carry = 1'b0;
    case (r_op)
      OP_ADD:  w_carry = w_sum_ext[WIDTH];
      OP_SUB:  w_carry = ~w_diff_ext[WIDTH];
      default: w_carry = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (w_ld_z) begin
      r_flag_z <= (w_alu == '0);
      r_flag_n <= w_alu[WIDTH-1];
      r_flag_c <= w_carry;
    end
  end

  assign o_flag_z = r_flag_z;
  assign o_flag_n = r_flag_n;
  assign o_flag_c = r_flag_c;
`else
  assign w_sum  = r_y + w_bus;
  assign w_diff = r_y - w_bus;
`endif

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = w_sum;
      OP_SUB:  w_alu = w_diff;
      OP_AND:  w_alu = r_y & w_bus;
      OP_OR:   w_alu = r_y | w_bus;
      OP_XOR:  w_alu = r_y ^ w_bus;
      OP_SHL:  w_alu = r_y << w_shamt;
      OP_SHR:  w_alu = r_y >> w_shamt;
      default: w_alu = w_bus;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_y   <= '0;
      r_z   <= '0;
      r_op  <= OP_ADD;
      r_rd  <= '0;
      r_rs  <= '0;
      r_rt  <= '0;
      r_imm <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= bus_if.cmd_op;
        r_rd  <= bus_if.cmd_rd;
        r_rs  <= bus_if.cmd_rs;
        r_rt  <= bus_if.cmd_rt;
        r_imm <= bus_if.cmd_imm;
      end
      if (w_ld_y) r_y <= w_bus;
      if (w_ld_z) r_z <= w_alu;
      if (w_wb)   r_regs[r_rd] <= w_bus;
    end
  end

  assign bus_if.cmd_ready = w_ready;
  assign bus_if.done      = w_done;
  assign bus_if.bus_out   = w_bus;
  assign o_dbg_data       = r_regs[i_dbg_sel];

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: directed scenarios plus randomized commands against a behavioural register-file model.
module tb_datapath_seq;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic [AW-1:0]    dbg_sel;
  logic [WIDTH-1:0] dbg_data;
`ifdef DATAPATH_FLAGS_EN
  logic flag_z, flag_n, flag_c;
`endif

  datapath_seq_if #(.WIDTH(WIDTH), .AW(AW)) dif ();

  datapath_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clock   (clock),
    .i_clear   (clear),
    .bus_if    (dif),
    .i_dbg_sel (dbg_sel),
    .o_dbg_data(dbg_data)
`ifdef DATAPATH_FLAGS_EN
    ,
    .o_flag_z  (flag_z),
    .o_flag_n  (flag_n),
    .o_flag_c  (flag_c)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic [WIDTH-1:0] m_regs [DEPTH];
  logic [WIDTH-1:0] exp_res;
`ifdef DATAPATH_FLAGS_EN
  logic exp_z, exp_n, exp_c;
  logic obs_fz, obs_fn, obs_fc;
`endif

  // observations of the last command, index 0 = first cycle after accept
  logic [3:0]       obs_done;
  logic [3:0]       obs_ready;
  logic [WIDTH-1:0] obs_bus [4];
  logic [WIDTH-1:0] obs_dbg;
  logic             obs_ready_acc;

  function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] imm);
    longint unsigned ua = a;
    longint unsigned ub = b;
    case (op)
      3'd0:    return WIDTH'(ua + ub);
      3'd1:    return WIDTH'(ua - ub);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return WIDTH'(ua << (ub % WIDTH));
      3'd6:    return WIDTH'(ua >> (ub % WIDTH));
      default: return imm;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
`ifdef DATAPATH_FLAGS_EN
    exp_z = 1'b0; exp_n = 1'b0; exp_c = 1'b0;
`endif
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                             input logic [AW-1:0] rt, input logic [WIDTH-1:0] imm);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = m_regs[rs];
    b = m_regs[rt];
    exp_res = ref_result(op, a, b, imm);
`ifdef DATAPATH_FLAGS_EN
    exp_z = (exp_res == 0);
    exp_n = exp_res[WIDTH-1];
    if (op == 3'd0)      exp_c = ((longint'(a) + longint'(b)) >> WIDTH) != 0;
    else if (op == 3'd1) exp_c = (a >= b);
    else                 exp_c = 1'b0;
`endif
    m_regs[rd] = exp_res;
  endtask

  // Drives one command starting at a falling edge and records four cycles of outputs.
  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [WIDTH-1:0] imm);
    dif.cmd_valid = 1'b1;
    dif.cmd_op    = op;
    dif.cmd_rd    = rd;
    dif.cmd_rs    = rs;
    dif.cmd_rt    = rt;
    dif.cmd_imm   = imm;
    dbg_sel       = rd;
    #1 obs_ready_acc = dif.cmd_ready;
    @(posedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      obs_done[k]  = dif.done;
      obs_ready[k] = dif.cmd_ready;
      obs_bus[k]   = dif.bus_out;
      if (k == 0) begin
        dif.cmd_valid = 1'b0;
        dif.cmd_imm   = $urandom;
        dif.cmd_rd    = AW'($urandom);
      end
    end
    obs_dbg = dbg_data;
`ifdef DATAPATH_FLAGS_EN
    obs_fz = flag_z; obs_fn = flag_n; obs_fc = flag_c;
`endif
  endtask

  task automatic test_reset();
    clear = 1'b0;
    dif.cmd_valid = 1'b1;
    dif.cmd_op = 3'd0; dif.cmd_rd = 4'd3; dif.cmd_rs = 4'd1; dif.cmd_rt = 4'd2; dif.cmd_imm = 32'hDEAD_BEEF;
    dbg_sel = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      n_vec++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL reset_done cyc=%0d got=%b exp=0", c, dif.done); end
      n_vec++; if (dif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", c, dif.cmd_ready); end
      n_vec++; if (dif.bus_out !== '0) begin n_err++; $display("FAIL reset_bus cyc=%0d got=%h exp=0", c, dif.bus_out); end
    end
    clear = 1'b1;
    dif.cmd_valid = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      dbg_sel = AW'(i);
      #1;
      n_vec++; if (dbg_data !== m_regs[i]) begin n_err++; $display("FAIL reset_reg R%0d got=%h exp=%h", i, dbg_data, m_regs[i]); end
    end
`ifdef DATAPATH_FLAGS_EN
    n_vec++; if ({flag_z, flag_n, flag_c} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {flag_z, flag_n, flag_c}); end
`endif
    @(negedge clock);
  endtask

  task automatic test_ldi_add();
    run_cmd(3'd7, 4'd1, 4'd0, 4'd0, 32'd5); model_apply(3'd7, 4'd1, 4'd0, 4'd0, 32'd5);
    n_vec++; if (obs_done !== 4'b0010) begin n_err++; $display("FAIL ldi1_done_timing got=%b exp=0010", obs_done); end
    n_vec++; if (obs_dbg !== 32'd5) begin n_err++; $display("FAIL ldi1_value got=%h exp=5", obs_dbg); end
    run_cmd(3'd7, 4'd2, 4'd0, 4'd0, 32'd7); model_apply(3'd7, 4'd2, 4'd0, 4'd0, 32'd7);
    n_vec++; if (obs_done !== 4'b0010) begin n_err++; $display("FAIL ldi2_done_timing got=%b exp=0010", obs_done); end
    n_vec++; if (obs_dbg !== 32'd7) begin n_err++; $display("FAIL ldi2_value got=%h exp=7", obs_dbg); end
    run_cmd(3'd0, 4'd3, 4'd1, 4'd2, 32'd0); model_apply(3'd0, 4'd3, 4'd1, 4'd2, 32'd0);
    n_vec++; if (obs_done !== 4'b0100) begin n_err++; $display("FAIL add_done_timing got=%b exp=0100", obs_done); end
    n_vec++; if (obs_ready !== 4'b1000) begin n_err++; $display("FAIL add_ready got=%b exp=1000", obs_ready); end
    n_vec++; if (obs_bus[0] !== 32'd5) begin n_err++; $display("FAIL add_bus_t1 got=%h exp=5", obs_bus[0]); end
    n_vec++; if (obs_bus[1] !== 32'd7) begin n_err++; $display("FAIL add_bus_t2 got=%h exp=7", obs_bus[1]); end
    n_vec++; if (obs_bus[2] !== 32'd12) begin n_err++; $display("FAIL add_bus_t3 got=%h exp=c", obs_bus[2]); end
    n_vec++; if (obs_dbg !== 32'd12) begin n_err++; $display("FAIL add_result got=%h exp=c", obs_dbg); end
  endtask

  task automatic test_wrap_alias();
    run_cmd(3'd7, 4'd4, 4'd0, 4'd0, 32'hFFFF_FFFF); model_apply(3'd7, 4'd4, 4'd0, 4'd0, 32'hFFFF_FFFF);
    run_cmd(3'd0, 4'd4, 4'd4, 4'd4, 32'd0); model_apply(3'd0, 4'd4, 4'd4, 4'd4, 32'd0);
    n_vec++; if (obs_dbg !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wrap_alias got=%h exp=fffffffe", obs_dbg); end
`ifdef DATAPATH_FLAGS_EN
    n_vec++; if ({obs_fz, obs_fn, obs_fc} !== 3'b011) begin n_err++; $display("FAIL wrap_flags znc got=%b exp=011", {obs_fz, obs_fn, obs_fc}); end
`endif
  endtask

  task automatic test_ops();
    run_cmd(3'd1, 4'd5, 4'd1, 4'd2, 32'd0); model_apply(3'd1, 4'd5, 4'd1, 4'd2, 32'd0);
    n_vec++; if (obs_dbg !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub got=%h exp=fffffffe", obs_dbg); end
`ifdef DATAPATH_FLAGS_EN
    n_vec++; if (obs_fc !== 1'b0) begin n_err++; $display("FAIL sub_carry got=%b exp=0", obs_fc); end
`endif
    run_cmd(3'd4, 4'd6, 4'd1, 4'd2, 32'd0); model_apply(3'd4, 4'd6, 4'd1, 4'd2, 32'd0);
    n_vec++; if (obs_dbg !== 32'd2) begin n_err++; $display("FAIL xor got=%h exp=2", obs_dbg); end
    run_cmd(3'd7, 4'd7, 4'd0, 4'd0, 32'd35); model_apply(3'd7, 4'd7, 4'd0, 4'd0, 32'd35);
    run_cmd(3'd5, 4'd8, 4'd1, 4'd7, 32'd0); model_apply(3'd5, 4'd8, 4'd1, 4'd7, 32'd0);
    n_vec++; if (obs_dbg !== 32'h28) begin n_err++; $display("FAIL shl got=%h exp=28", obs_dbg); end
    run_cmd(3'd6, 4'd9, 4'd4, 4'd7, 32'd0); model_apply(3'd6, 4'd9, 4'd4, 4'd7, 32'd0);
    n_vec++; if (obs_dbg !== 32'h1FFF_FFFF) begin n_err++; $display("FAIL shr got=%h exp=1fffffff", obs_dbg); end
  endtask

  task automatic test_random();
    logic [2:0]       op;
    logic [AW-1:0]    rd, rs, rt;
    logic [WIDTH-1:0] imm;
    logic [3:0]       exp_done, exp_ready;
    logic [WIDTH-1:0] bus_at_done;
    for (int n = 0; n < 60; n++) begin
      op  = 3'($urandom_range(0, 7));
      rd  = AW'($urandom);
      rs  = AW'($urandom);
      rt  = AW'($urandom);
      imm = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      if (n < 16) op = 3'd7;
      run_cmd(op, rd, rs, rt, imm);
      model_apply(op, rd, rs, rt, imm);
      exp_done    = (op == 3'd7) ? 4'b0010 : 4'b0100;
      exp_ready   = (op == 3'd7) ? 4'b1100 : 4'b1000;
      bus_at_done = (op == 3'd7) ? obs_bus[1] : obs_bus[2];
      n_vec++; if (obs_ready_acc !== 1'b1) begin n_err++; $display("FAIL rnd_ready_acc n=%0d got=%b exp=1", n, obs_ready_acc); end
      n_vec++; if (obs_done !== exp_done) begin n_err++; $display("FAIL rnd_done n=%0d op=%0d got=%b exp=%b", n, op, obs_done, exp_done); end
      n_vec++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready n=%0d op=%0d got=%b exp=%b", n, op, obs_ready, exp_ready); end
      n_vec++; if (bus_at_done !== exp_res) begin n_err++; $display("FAIL rnd_bus n=%0d op=%0d got=%h exp=%h", n, op, bus_at_done, exp_res); end
      n_vec++; if (obs_dbg !== m_regs[rd]) begin n_err++; $display("FAIL rnd_reg n=%0d op=%0d R%0d got=%h exp=%h", n, op, rd, obs_dbg, m_regs[rd]); end
`ifdef DATAPATH_FLAGS_EN
      n_vec++; if ({obs_fz, obs_fn, obs_fc} !== {exp_z, exp_n, exp_c}) begin n_err++; $display("FAIL rnd_flags n=%0d op=%0d got=%b exp=%b", n, op, {obs_fz, obs_fn, obs_fc}, {exp_z, exp_n, exp_c}); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    logic [WIDTH-1:0] imm;
    // ALU ops with valid held high: one accept every 4 cycles
    n_done = 0;
    dif.cmd_valid = 1'b1;
    dif.cmd_op = 3'd0; dif.cmd_rd = 4'd10; dif.cmd_rs = 4'd10; dif.cmd_rt = 4'd11;
    dbg_sel = 4'd10;
    for (int k = 0; k < 12; k++) begin
      n_vec++; if (dif.cmd_ready !== (k % 4 == 0)) begin n_err++; $display("FAIL b2b_alu_ready k=%0d got=%b exp=%b", k, dif.cmd_ready, (k % 4 == 0)); end
      if (dif.done === 1'b1) n_done++;
      if (k % 4 == 0) model_apply(3'd0, 4'd10, 4'd10, 4'd11, 32'd0);
      @(negedge clock);
    end
    dif.cmd_valid = 1'b0;
    n_vec++; if (n_done != 3) begin n_err++; $display("FAIL b2b_alu_done_count got=%0d exp=3", n_done); end
    n_vec++; if (dbg_data !== m_regs[10]) begin n_err++; $display("FAIL b2b_alu_value got=%h exp=%h", dbg_data, m_regs[10]); end
    @(negedge clock);
    // LDI with valid held high: one accept every 3 cycles
    n_done = 0;
    dif.cmd_valid = 1'b1;
    dif.cmd_op = 3'd7; dif.cmd_rd = 4'd12;
    dbg_sel = 4'd12;
    for (int k = 0; k < 9; k++) begin
      n_vec++; if (dif.cmd_ready !== (k % 3 == 0)) begin n_err++; $display("FAIL b2b_ldi_ready k=%0d got=%b exp=%b", k, dif.cmd_ready, (k % 3 == 0)); end
      if (dif.done === 1'b1) n_done++;
      if (k % 3 == 0) begin
        imm = $urandom;
        dif.cmd_imm = imm;
        model_apply(3'd7, 4'd12, 4'd0, 4'd0, imm);
      end
      @(negedge clock);
    end
    dif.cmd_valid = 1'b0;
    n_vec++; if (n_done != 3) begin n_err++; $display("FAIL b2b_ldi_done_count got=%0d exp=3", n_done); end
    n_vec++; if (dbg_data !== m_regs[12]) begin n_err++; $display("FAIL b2b_ldi_value got=%h exp=%h", dbg_data, m_regs[12]); end
    @(negedge clock);
  endtask

  task automatic test_abort();
    run_cmd(3'd7, 4'd1, 4'd0, 4'd0, 32'd5); model_apply(3'd7, 4'd1, 4'd0, 4'd0, 32'd5);
    run_cmd(3'd7, 4'd2, 4'd0, 4'd0, 32'd7); model_apply(3'd7, 4'd2, 4'd0, 4'd0, 32'd7);
    dif.cmd_valid = 1'b1;
    dif.cmd_op = 3'd0; dif.cmd_rd = 4'd3; dif.cmd_rs = 4'd1; dif.cmd_rt = 4'd2;
    @(posedge clock);
    @(negedge clock);
    dif.cmd_valid = 1'b0;
    n_vec++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL abort_done_t1 got=%b exp=0", dif.done); end
    @(negedge clock);
    n_vec++; if (dif.bus_out !== 32'd7) begin n_err++; $display("FAIL abort_bus_t2 got=%h exp=7", dif.bus_out); end
    clear = 1'b0;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    model_reset();
    n_vec++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL abort_done_after got=%b exp=0", dif.done); end
    n_vec++; if (dif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got=%b exp=1", dif.cmd_ready); end
    dbg_sel = 4'd3;
    #1;
    n_vec++; if (dbg_data !== m_regs[3]) begin n_err++; $display("FAIL abort_no_writeback got=%h exp=%h", dbg_data, m_regs[3]); end
    dbg_sel = 4'd1;
    #1;
    n_vec++; if (dbg_data !== m_regs[1]) begin n_err++; $display("FAIL abort_reg_clear got=%h exp=%h", dbg_data, m_regs[1]); end
    @(negedge clock);
    n_vec++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL abort_late_done got=%b exp=0", dif.done); end
    run_cmd(3'd7, 4'd3, 4'd0, 4'd0, 32'd9); model_apply(3'd7, 4'd3, 4'd0, 4'd0, 32'd9);
    n_vec++; if (obs_dbg !== 32'd9) begin n_err++; $display("FAIL abort_recover got=%h exp=9", obs_dbg); end
  endtask

  initial begin
    dif.cmd_valid = 1'b0;
    dif.cmd_op = '0; dif.cmd_rd = '0; dif.cmd_rs = '0; dif.cmd_rt = '0; dif.cmd_imm = '0;
    dbg_sel = '0;
    model_reset();
    test_reset();
    test_ldi_add();
    test_wrap_alias();
    test_ops();
    test_random();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
